// File: rtl/stream_mux_pkg.sv
// Shared constants for stream_mux: default geometry, FSM encoding and a wrap-around adder.
package stream_mux_pkg;

    localparam int unsigned DefWidth    = 16;
    localparam int unsigned DefChannels = 4;

    typedef enum logic {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } mux_state_e;

    // (base + off) mod modulus, assuming base < modulus and off < modulus.
    function automatic int unsigned wrap_add(int unsigned base, int unsigned off,
                                             int unsigned modulus);
        int unsigned sum;
        sum = base + off;
        return (sum >= modulus) ? sum - modulus : sum;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: first requester at or above i_rr_ptr, wrapping to 0.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned CHANNELS = DefChannels,
    parameter int unsigned SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [SELW-1:0]     i_rr_ptr,
    output logic [CHANNELS-1:0] o_gnt,
    output logic [SELW-1:0]     o_gnt_idx,
    output logic                o_gnt_valid
);

    logic [SELW-1:0] w_cand;

    always_comb begin
        o_gnt       = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        w_cand      = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_cand = SELW'(wrap_add(32'(i_rr_ptr), i, CHANNELS));
            if (!o_gnt_valid && i_req[w_cand]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_cand;
            end
        end
        o_gnt[o_gnt_idx] = o_gnt_valid;
    end

endmodule

// File: rtl/stream_mux.sv
// Packet-aware N:1 stream multiplexer with round-robin arbitration and a registered output stage.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned CHANNELS = DefChannels,
    parameter int unsigned SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [SELW-1:0]           out_sel,
    input  logic                      out_ready
);

    mux_state_e      r_state;
    mux_state_e      w_state_next;
    logic [SELW-1:0] r_gnt_idx;
    logic [SELW-1:0] w_gnt_next;
    logic [SELW-1:0] r_rr_ptr;
    logic [SELW-1:0] w_rr_next;
    logic            r_live;
    logic            r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic            r_out_last;
    logic [SELW-1:0] r_out_sel;

    logic [CHANNELS-1:0] w_arb_gnt;
    logic [SELW-1:0]     w_arb_idx;
    logic                w_arb_valid;
    logic                w_can_load;
    logic [SELW-1:0]     w_sel_idx;
    logic                w_accept;
    logic                w_sel_last;
    logic [WIDTH-1:0]    w_sel_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_arb (
        .i_req       (in_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_gnt       (w_arb_gnt),
        .o_gnt_idx   (w_arb_idx),
        .o_gnt_valid (w_arb_valid)
    );

    // r_live blocks acceptance on the first edge after reset release.
    assign w_can_load = r_live && (!r_out_valid || out_ready);
    assign w_sel_idx  = (r_state == StLocked) ? r_gnt_idx : w_arb_idx;
    assign w_sel_last = in_last[w_sel_idx];
    assign w_sel_data = in_data[w_sel_idx*WIDTH +: WIDTH];
    assign w_accept   = |(in_valid & in_ready);

    always_comb begin
        in_ready = '0;
        if (w_can_load) begin
            if (r_state == StLocked) begin
                in_ready[r_gnt_idx] = 1'b1;
            end else if (w_arb_valid) begin
                in_ready = w_arb_gnt;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt_idx;
        w_rr_next    = r_rr_ptr;
        if (w_accept) begin
            if (w_sel_last) begin
                w_state_next = StIdle;
                w_rr_next    = SELW'(wrap_add(32'(w_sel_idx), 1, CHANNELS));
            end else begin
                w_state_next = StLocked;
                w_gnt_next   = w_sel_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_gnt_idx   <= '0;
            r_rr_ptr    <= '0;
            r_live      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else begin
            r_live    <= 1'b1;
            r_state   <= w_state_next;
            r_gnt_idx <= w_gnt_next;
            r_rr_ptr  <= w_rr_next;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_last  <= w_sel_last;
                r_out_sel   <= w_sel_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width per channel in bits.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels, 2..16.
REQ-003 SHALL have parameter SELW, default clog2(CHANNELS), width of channel index.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  CHANNELS  per-channel beat valid.
REQ-007 SHALL have port in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_last  input  CHANNELS  per-channel last-beat-of-packet flag.
REQ-009 SHALL have port in_ready  output  CHANNELS  per-channel accept; one-hot or zero.
REQ-010 SHALL have port out_valid  output  1  registered output holds a beat.
REQ-011 SHALL have port out_data  output  WIDTH  registered beat data.
REQ-012 SHALL have port out_last  output  1  registered last flag.
REQ-013 SHALL have port out_sel  output  SELW  index of the source channel of the registered beat.
REQ-014 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-015 SHALL transfer an input beat on channel i when in_valid[i] and in_ready[i] are both high at a rising edge.
REQ-016 SHALL transfer an output beat when out_valid and out_ready are both high at a rising edge.
REQ-017 SHALL drive in_ready[i] high only for the granted channel g, and only when the output register is empty or out_ready is high (load-while-drain).
REQ-018 SHALL present an accepted beat on out_* exactly 1 cycle after acceptance; throughput is 1 beat/cycle with out_ready held high.
REQ-019 SHALL keep out_data, out_last and out_sel stable while out_valid is high and out_ready is low.
REQ-020 SHALL implement FSM states IDLE (no packet in progress) and LOCKED (grant held on channel g).
REQ-021 In IDLE, SHALL grant combinationally the first channel with in_valid high, searching from rr_ptr upward and wrapping from CHANNELS-1 to 0.
REQ-022 In IDLE, SHALL remain IDLE on acceptance of a beat with in_last=1, and SHALL go to LOCKED with g=granted channel on acceptance of a beat with in_last=0.
REQ-023 In LOCKED, SHALL ignore all channels other than g, even if channel g is not valid.
REQ-024 In LOCKED, SHALL return to IDLE on acceptance of a beat with in_last=1.
REQ-025 SHALL set rr_ptr to (g+1) mod CHANNELS when a last beat from channel g is accepted; rr_ptr is otherwise unchanged.
REQ-026 SHALL NOT change grant or state when no beat is accepted, including when the output register is stalled.
REQ-027 With no in_valid high in IDLE, SHALL drive in_ready all zero and hold rr_ptr.

Reset
REQ-028 On rst_n low, SHALL asynchronously force state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_last=0, out_sel=0 and in_ready=0.
REQ-029 Reset mid-packet SHALL discard the partial packet and the held output beat; no beat is emitted after reset until a new acceptance.
REQ-030 SHALL accept no beat on the first rising edge at which rst_n is already high but was low at the preceding edge.

Structure
REQ-031 Default WIDTH/CHANNELS and FSM state encodings SHALL reside in a shared constants include used by the block and its bench.
REQ-032 The round-robin priority search SHALL be a sub-module rr_arbiter (inputs: request vector, rr_ptr; outputs: one-hot grant, grant index).
REQ-033 The data path SHALL select with an indexed part-select on in_data, not per-bit mux instances.

Verification
REQ-034 Bench: reset, then ch0 and ch2 valid with single-beat packets (last=1), data 0x1111/0x2222, out_ready=1 -> out_sel sequence 0,2,0,2; data matches; 1 beat/cycle.
REQ-035 Bench: ch1 sends 3-beat packet 0xA001..0xA003 while ch3 is valid throughout -> ch1 beats contiguous on output; ch3 granted only after 0xA003 accepted.
REQ-036 Bench: out_ready=0 for 5 cycles with out_valid=1 -> out_* stable; in_ready all 0; grant and rr_ptr unchanged; release -> no beat lost or duplicated.
REQ-037 Bench: all 4 channels valid with single-beat packets, rr_ptr=3 -> grant order 3,0,1,2.
REQ-038 Bench: assert rst_n low on second beat of a 4-beat packet on ch2 -> out_valid=0 immediately; after release, ch0 single beat 0x0F0F granted first with out_sel=0.
REQ-039 Bench: run scenarios 1 and 3 at CHANNELS=2, WIDTH=8 and at CHANNELS=16, WIDTH=32 -> identical ordering rules hold.
